pipeline_hazard_ctrl: RTL and testbench

Parametrised pipeline controller for an N-stage in-order pipeline. Stage 0 is fetch and stage NUM_STAGES-1 is the oldest stage. The block takes per-stage stall requests, per-stage flush (redirect) requests and a timed multi-cycle stall. It produces per-stage hold and flush strobes, and tracks a registered valid bit for each stage, inserting bubbles where held and unheld stages meet. It sits beside the stage datapaths; each stage gates its pipeline registers with stall_o[i] and clears its valid or instruction on flush_o[i].

---
 rtl/pipeline_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hold/flush controller for an N-stage in-order pipeline, with a timed multi-cycle stall.
// Optional stall/flush performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES  = 3,
    parameter int STALL_CNT_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [NUM_STAGES-1:0]  stall_req,
    input  logic [NUM_STAGES-1:0]  flush_req,
    input  logic                   stall_load,
    input  logic [STALL_CNT_W-1:0] stall_len,
    output logic [NUM_STAGES-1:0]  stall_o,
    output logic [NUM_STAGES-1:0]  flush_o,
    output logic [NUM_STAGES-1:0]  valid_o,
    output logic                   busy_o,
    output logic [31:0]            stall_cycles_o,
    output logic [15:0]            flush_count_o
);

    logic [STALL_CNT_W-1:0] cnt;
    logic                   timed_active;
    logic                   stall_acc;
    logic                   flush_acc;
    logic [NUM_STAGES-1:0]  valid;
    logic [NUM_STAGES-1:0]  valid_next;

    assign timed_active = (cnt != '0);
    assign busy_o       = timed_active;
    assign valid_o      = valid;

    // Walk from the oldest stage down: a stall holds its stage and all younger ones,
    // a flush kills strictly younger stages only.
    always_comb begin
        stall_acc = 1'b0;
        flush_acc = 1'b0;
        stall_o   = '0;
        flush_o   = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            stall_acc  = stall_acc | stall_req[i];
            stall_o[i] = (timed_active | stall_acc) & ~reset;
            flush_o[i] = flush_acc & ~reset;
            flush_acc  = flush_acc | flush_req[i];
        end
    end

    // A held stage feeding an unheld one passes a bubble downstream.
    always_comb begin
        valid_next = '0;
        if (flush_o[0])
            valid_next[0] = 1'b0;
        else if (stall_o[0])
            valid_next[0] = valid[0];
        else
            valid_next[0] = fetch_valid;
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (flush_o[i])
                valid_next[i] = 1'b0;
            else if (stall_o[i])
                valid_next[i] = valid[i];
            else
                valid_next[i] = stall_o[i-1] ? 1'b0 : valid[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            valid <= '0;
        else
            valid <= valid_next;
    end

    // A nonzero load restarts the stall even mid-count; a zero-length load is a no-op.
    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (stall_load && (stall_len != '0))
            cnt <= stall_len;
        else if (timed_active)
            cnt <= cnt - STALL_CNT_W'(1);
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_o[0] && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if ((flush_o != '0) && (flush_count != '1))
                flush_count <= flush_count + 16'd1;
        end
    end

    assign stall_cycles_o = stall_cycles;
    assign flush_count_o  = flush_count;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (NUM_STAGES=3, STALL_CNT_W=4).
// Performance counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipeline_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic        fetch_valid;
    logic [2:0]  stall_req;
    logic [2:0]  flush_req;
    logic        stall_load;
    logic [3:0]  stall_len;
    logic [2:0]  stall_o;
    logic [2:0]  flush_o;
    logic [2:0]  valid_o;
    logic        busy_o;
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;

    int tests_run;
    int fail_count;

    pipeline_hazard_ctrl #(
        .NUM_STAGES (3),
        .STALL_CNT_W(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .stall_req     (stall_req),
        .flush_req     (flush_req),
        .stall_load    (stall_load),
        .stall_len     (stall_len),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .valid_o       (valid_o),
        .busy_o        (busy_o),
        .stall_cycles_o(stall_cycles_o),
        .flush_count_o (flush_count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic rst, input logic fv, input logic [2:0] sreq,
                                 input logic [2:0] freq, input logic ld, input logic [3:0] len);
        reset       = rst;
        fetch_valid = fv;
        stall_req   = sreq;
        flush_req   = freq;
        stall_load  = ld;
        stall_len   = len;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] exp_stall_cycles;
        logic [15:0] exp_flush_count;
        tests_run  = 0;
        fail_count = 0;

        // Reset state; strobes stay low under reset even with requests asserted.
        applyStimulus(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 4'd0);
        tick();
        tick();
        checkOutput("reset_valid", 32'(valid_o), 32'h0);
        checkOutput("reset_busy", 32'(busy_o), 32'h0);
        checkOutput("reset_stall_cycles", stall_cycles_o, 32'h0);
        checkOutput("reset_flush_count", 32'(flush_count_o), 32'h0);
        applyStimulus(1'b1, 1'b1, 3'b111, 3'b111, 1'b0, 4'd0);
        checkOutput("reset_masks_stall", 32'(stall_o), 32'h0);
        checkOutput("reset_masks_flush", 32'(flush_o), 32'h0);

        // Fill the pipeline.
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 4'd0);
        checkOutput("fill_stall", 32'(stall_o), 32'h0);
        checkOutput("fill_flush", 32'(flush_o), 32'h0);
        tick();
        checkOutput("fill_valid_1", 32'(valid_o), 32'b001);
        tick();
        checkOutput("fill_valid_2", 32'(valid_o), 32'b011);
        tick();
        checkOutput("fill_valid_3", 32'(valid_o), 32'b111);
        tick();
        checkOutput("fill_valid_4", 32'(valid_o), 32'b111);

        // Stage 1 stalls for two cycles: bubble into stage 2.
        applyStimulus(1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 4'd0);
        checkOutput("stall1_mask", 32'(stall_o), 32'b011);
        checkOutput("stall1_flush", 32'(flush_o), 32'h0);
        tick();
        checkOutput("stall1_valid_a", 32'(valid_o), 32'b011);
        checkOutput("stall1_mask_b", 32'(stall_o), 32'b011);
        tick();
        checkOutput("stall1_valid_b", 32'(valid_o), 32'b011);
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 4'd0);
        checkOutput("stall1_release", 32'(stall_o), 32'h0);
        tick();
        checkOutput("stall1_resume", 32'(valid_o), 32'b111);

        // Flush from stage 2 beats the hold on stage 0.
        applyStimulus(1'b0, 1'b1, 3'b001, 3'b100, 1'b0, 4'd0);
        checkOutput("flush2_mask", 32'(flush_o), 32'b011);
        checkOutput("flush2_stall", 32'(stall_o), 32'b001);
        tick();
        checkOutput("flush2_valid", 32'(valid_o), 32'b100);
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 4'd0);
        tick();
        checkOutput("refill_1", 32'(valid_o), 32'b001);
        tick();
        checkOutput("refill_2", 32'(valid_o), 32'b011);
        tick();
        checkOutput("refill_3", 32'(valid_o), 32'b111);

        // Timed stall of 3, reloaded with 5 on its second cycle.
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 4'd3);
        checkOutput("timed_not_yet", 32'(stall_o), 32'h0);
        checkOutput("timed_not_yet_busy", 32'(busy_o), 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 4'd0);
        checkOutput("timed_c1_busy", 32'(busy_o), 32'h1);
        checkOutput("timed_c1_stall", 32'(stall_o), 32'b111);
        checkOutput("timed_c1_valid", 32'(valid_o), 32'b111);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 4'd5);
        checkOutput("timed_c2_busy", 32'(busy_o), 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("reload_busy_%0d", k), 32'(busy_o), 32'h1);
            checkOutput($sformatf("reload_stall_%0d", k), 32'(stall_o), 32'b111);
            tick();
        end
        checkOutput("timed_done_busy", 32'(busy_o), 32'h0);
        checkOutput("timed_done_stall", 32'(stall_o), 32'h0);
        checkOutput("timed_done_valid", 32'(valid_o), 32'b111);

        // Zero-length load is ignored.
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 4'd0);
        checkOutput("zero_load_busy", 32'(busy_o), 32'h0);
        checkOutput("zero_load_valid", 32'(valid_o), 32'b110);

        // Reset lands mid-stall (cnt=2) with a flush pending.
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 4'd4);
        tick();
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 4'd0);
        checkOutput("pre_reset_valid", 32'(valid_o), 32'b101);
        tick();
        tick();
        checkOutput("pre_reset_busy", 32'(busy_o), 32'h1);
        applyStimulus(1'b1, 1'b1, 3'b000, 3'b010, 1'b0, 4'd0);
        checkOutput("mid_reset_stall", 32'(stall_o), 32'h0);
        checkOutput("mid_reset_flush", 32'(flush_o), 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 4'd0);
        checkOutput("post_reset_valid", 32'(valid_o), 32'h0);
        checkOutput("post_reset_busy", 32'(busy_o), 32'h0);
        checkOutput("post_reset_stall", 32'(stall_o), 32'h0);
        checkOutput("post_reset_flush", 32'(flush_o), 32'h0);
        checkOutput("post_reset_perf", stall_cycles_o, 32'h0);

        // Own flush does not kill itself; union of masks with multiple requesters.
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 4'd0);
        checkOutput("flush0_mask", 32'(flush_o), 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 4'd0);
        checkOutput("flush1_mask", 32'(flush_o), 32'b001);

        // Performance counters: 4 stall cycles, then 2 flush cycles.
        applyStimulus(1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 4'd0);
        for (int k = 0; k < 4; k++) tick();
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b100, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b110, 1'b0, 4'd0);
        checkOutput("flush_union_mask", 32'(flush_o), 32'b011);
        tick();
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 4'd0);
`ifdef PIPE_CTRL_PERF_EN
        exp_stall_cycles = 32'd4;
        exp_flush_count  = 16'd2;
`else
        exp_stall_cycles = 32'd0;
        exp_flush_count  = 16'd0;
`endif
        checkOutput("perf_stall_cycles", stall_cycles_o, exp_stall_cycles);
        checkOutput("perf_flush_count", 32'(flush_count_o), 32'(exp_flush_count));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
